// File: rtl/mem_xlate_ctrl.sv
// Load/store sequencer: core request -> MMU translation -> data bus -> ack/exception.
// Optional bus watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_xlate_ctrl #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter bit          ALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Core_Req,
  input  logic        Core_We,
  input  logic [31:0] Core_VAddr,
  input  logic [31:0] Core_WData,
  input  logic [3:0]  Core_BE,
  output logic        Core_Ready,
  output logic        Core_Ack,
  output logic [31:0] Core_RData,
  output logic        Core_Exc,
  output logic [2:0]  Core_ExcCode,
  output logic [31:0] Core_BadVAddr,
  output logic        Pr_Req,
  output logic        RW_En,
  output logic [31:0] Pr_VAddr,
  input  logic        MMU_Pr_Ack,
  input  logic [31:0] MMU_Pr_RAddr,
  input  logic        TLB_Error,
  input  logic [2:0]  TLB_Fault,
  output logic        Bus_Req,
  output logic        Bus_We,
  output logic [31:0] Bus_Addr,
  output logic [31:0] Bus_WData,
  output logic [3:0]  Bus_BE,
  input  logic        Bus_Ack,
  input  logic [31:0] Bus_RData
);

  localparam logic [2:0] CodeAddr     = 3'd1;
  localparam logic [2:0] CodeTlbMiss  = 3'd2;
  localparam logic [2:0] CodeTlbInv   = 3'd3;
  localparam logic [2:0] CodeTlbMod   = 3'd4;
`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [2:0] CodeTimeout  = 3'd5;
`endif

  if (TIMEOUT_W == 0) begin : g_bad_timeout_w
    $error("TIMEOUT_W must be nonzero");
  end

  typedef enum logic [2:0] {StIdle, StXlate, StBus, StResp, StFault} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  code_q, code_d;

`ifdef MEM_BUS_TIMEOUT_EN
  // Last count value before expiry: the BUS cycle that sees it is cycle 2^W-1.
  localparam logic [TIMEOUT_W-1:0] CntLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] CntOne  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    vaddr_d = vaddr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    paddr_d = paddr_q;
    rdata_d = rdata_q;
    code_d  = code_q;
`ifdef MEM_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (Core_Req) begin
          we_d    = Core_We;
          vaddr_d = Core_VAddr;
          wdata_d = Core_WData;
          be_d    = Core_BE;
          if (ALIGN_CHK && (Core_BE == 4'hF) && (Core_VAddr[1:0] != 2'b00)) begin
            code_d  = CodeAddr;
            state_d = StFault;
          end else begin
            state_d = StXlate;
          end
        end
      end
      StXlate: begin
        if (MMU_Pr_Ack) begin
          if (TLB_Error) begin
            code_d  = CodeAddr;
            state_d = StFault;
          end else if (TLB_Fault[2]) begin
            code_d  = CodeTlbMiss;
            state_d = StFault;
          end else if (TLB_Fault[1]) begin
            code_d  = CodeTlbInv;
            state_d = StFault;
          end else if (TLB_Fault[0] && we_q) begin
            code_d  = CodeTlbMod;
            state_d = StFault;
          end else begin
            paddr_d = MMU_Pr_RAddr;
            state_d = StBus;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StBus: begin
        if (Bus_Ack) begin
          if (!we_q) begin
            rdata_d = Bus_RData;
          end
          state_d = StResp;
`ifdef MEM_BUS_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          code_d  = CodeTimeout;
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + CntOne;
`endif
        end
      end
      StResp:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      vaddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      paddr_q <= '0;
      rdata_q <= '0;
      code_q  <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      vaddr_q <= vaddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      paddr_q <= paddr_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    Core_Ready    = (state_q == StIdle);
    Core_Ack      = (state_q == StResp);
    Core_RData    = rdata_q;
    Core_Exc      = (state_q == StFault);
    Core_ExcCode  = (state_q == StFault) ? code_q : 3'd0;
    Core_BadVAddr = (state_q == StFault) ? vaddr_q : 32'd0;
    Pr_Req        = (state_q == StXlate);
    RW_En         = we_q;
    Pr_VAddr      = vaddr_q;
    Bus_Req       = (state_q == StBus);
    Bus_We        = (state_q == StBus) && we_q;
    Bus_Addr      = paddr_q;
    Bus_WData     = wdata_q;
    Bus_BE        = be_q;
  end

endmodule
